store_buffer: RTL and testbench

Word-granular store buffer between the single-cycle core's load/store path and the data memory (asynchronous read, negedge-write, no simultaneous read and write). Core stores are accepted into a small FIFO and retired to memory on cycles the memory port is free. Loads that hit a buffered store are forwarded from the youngest matching entry; loads that miss read memory directly. The buffer stalls the core for one cycle only when a store arrives while the buffer is full.

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/sb_fwd_match.sv | 32 +++
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing helpers for the store buffer.
// Entries hold a word index plus the full data word.
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_WORD          = 32;
  localparam int SB_PTR_W         = $clog2(SB_DEPTH_DEFAULT);

  typedef struct packed {
    logic [SB_WORD-3:0] addr;
    logic [SB_WORD-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match forwarding selector over the store buffer entries.
// Scans oldest to youngest so the entry nearest the tail wins.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PW    = sb_ptr_w(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PW-1:0]         tail_i,
  input  logic [SB_WORD-3:0]    addr_i,
  output logic                  hit_o,
  output logic [SB_WORD-1:0]    data_o
);

  logic [PW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (valid_i[idx] && entries_i[idx].addr == addr_i) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer between core load/store path and data memory.
// Stores drain on cycles the memory port is free; loads forward from the youngest hit.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH    = SB_DEPTH_DEFAULT,
  parameter int WordSize = SB_WORD
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [WordSize-1:0] core_addr,
  input  logic                core_rd,
  input  logic                core_wr,
  input  logic [WordSize-1:0] core_din,
  output logic [WordSize-1:0] core_dout,
  output logic                core_stall,
  output logic [WordSize-1:0] Mem_Addr,
  output logic                Mem_rd,
  output logic                Mem_wr,
  output logic [WordSize-1:0] Mem_DIN,
  input  logic [WordSize-1:0] Mem_DOUT,
  output logic                sb_empty
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] ent_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;
  logic             hit;
  logic [WordSize-1:0] fwd_data;
  logic full, empty, ld_miss, drain, push;

  // An entry is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head_q;
      valid[i] = CW'(off) < count_q;
    end
  end

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_match (
    .entries_i(ent_q),
    .valid_i  (valid),
    .tail_i   (tail_q),
    .addr_i   (core_addr[WordSize-1:2]),
    .hit_o    (hit),
    .data_o   (fwd_data)
  );

  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign ld_miss = core_rd && !hit;
  assign drain   = !empty && !ld_miss && (!core_wr || full);
  assign push    = core_wr && !core_rd && !full;

  assign core_stall = core_wr && !core_rd && full;
  assign sb_empty   = empty;
  assign core_dout  = (core_rd && hit) ? fwd_data : Mem_DOUT;
  assign Mem_rd     = ld_miss;
  assign Mem_wr     = drain;
  assign Mem_Addr   = drain ? {ent_q[head_q].addr, 2'b00} : core_addr;
  assign Mem_DIN    = drain ? ent_q[head_q].data : '0;

  // Push and pop are mutually exclusive, so count moves by at most one.
  assign head_d  = drain ? head_q + PW'(1) : head_q;
  assign tail_d  = push ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(push) - CW'(drain);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q].addr <= core_addr[WordSize-1:2];
        ent_q[tail_q].data <= core_din;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;

  localparam int D = 4;

  logic        CLK;
  logic        Reset;
  logic [31:0] core_addr;
  logic        core_rd;
  logic        core_wr;
  logic [31:0] core_din;
  logic [31:0] core_dout;
  logic        core_stall;
  logic [31:0] Mem_Addr;
  logic        Mem_rd;
  logic        Mem_wr;
  logic [31:0] Mem_DIN;
  logic [31:0] Mem_DOUT;
  logic        sb_empty;

  store_buffer #(.DEPTH(D), .WordSize(32)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .core_addr (core_addr),
    .core_rd   (core_rd),
    .core_wr   (core_wr),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_stall(core_stall),
    .Mem_Addr  (Mem_Addr),
    .Mem_rd    (Mem_rd),
    .Mem_wr    (Mem_wr),
    .Mem_DIN   (Mem_DIN),
    .Mem_DOUT  (Mem_DOUT),
    .sb_empty  (sb_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data memory: asynchronous read, write on the falling edge.
  logic [31:0] mem [256];
  assign Mem_DOUT = mem[Mem_Addr[9:2]];
  always @(negedge CLK)
    if (Mem_wr) mem[Mem_Addr[9:2]] = Mem_DIN;

  int errs;
  int checks;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending stores as a FIFO, memory as a plain array.
  logic [29:0] qa [$];
  logic [31:0] qd [$];
  logic [31:0] ref_mem [256];
  bit          pend_pop;
  bit          pend_push;
  logic [29:0] pend_a;
  logic [31:0] pend_d;

  task automatic model_check();
    bit hit, full, miss, drain, push, stall;
    logic [31:0] hd;
    hit = 0;
    hd  = '0;
    if (Reset) begin
      qa.delete();
      qd.delete();
      chk("rst_mem_wr", {31'd0, Mem_wr}, 32'd0);
      chk("rst_stall", {31'd0, core_stall}, 32'd0);
      chk("rst_empty", {31'd0, sb_empty}, 32'd1);
      chk("rst_mem_rd", {31'd0, Mem_rd}, {31'd0, core_rd});
      if (core_rd) chk("rst_dout", core_dout, ref_mem[core_addr[9:2]]);
      return;
    end
    for (int k = qa.size() - 1; k >= 0 && !hit; k--)
      if (qa[k] == core_addr[31:2]) begin
        hit = 1;
        hd  = qd[k];
      end
    full  = qa.size() == D;
    miss  = core_rd && !hit;
    drain = qa.size() != 0 && !miss && (!core_wr || full);
    push  = core_wr && !core_rd && !full;
    stall = core_wr && !core_rd && full;
    if (core_rd)
      chk("m_dout", core_dout, hit ? hd : ref_mem[core_addr[9:2]]);
    chk("m_mem_rd", {31'd0, Mem_rd}, {31'd0, miss});
    chk("m_mem_wr", {31'd0, Mem_wr}, {31'd0, drain});
    if (drain) begin
      chk("m_mem_din", Mem_DIN, qd[0]);
      chk("m_mem_addr_wr", Mem_Addr, {qa[0], 2'b00});
    end else begin
      chk("m_mem_din0", Mem_DIN, 32'd0);
      if (miss) chk("m_mem_addr_rd", Mem_Addr, core_addr);
    end
    chk("m_stall", {31'd0, core_stall}, {31'd0, stall});
    chk("m_empty", {31'd0, sb_empty}, {31'd0, qa.size() == 0});
    pend_pop  = drain;
    pend_push = push;
    pend_a    = core_addr[31:2];
    pend_d    = core_din;
  endtask

  // Compare process: commit last cycle's model actions, then check mid-cycle.
  always @(posedge CLK) begin
    if (Reset) begin
      qa.delete();
      qd.delete();
    end else begin
      if (pend_pop) begin
        ref_mem[qa[0][7:0]] = qd[0];
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (pend_push) begin
        qa.push_back(pend_a);
        qd.push_back(pend_d);
      end
    end
    pend_pop  = 0;
    pend_push = 0;
    #4;
    model_check();
  end

  task automatic cyc(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d);
    @(posedge CLK);
    #1;
    core_rd   = rd;
    core_wr   = wr;
    core_addr = a;
    core_din  = d;
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 32'd0, 32'd0);
  endtask

  task automatic wait_empty(input string nm);
    for (int n = 0; n < 12 && !sb_empty; n++) idle();
    chk(nm, {31'd0, sb_empty}, 32'd1);
  endtask

  logic [31:0] wv [10];
  int          bad;
  bit          rd_r, wr_r;
  logic [31:0] a_r, d_r;

  initial begin
    errs      = 0;
    checks    = 0;
    pend_pop  = 0;
    pend_push = 0;
    Reset     = 1'b1;
    core_rd   = 1'b0;
    core_wr   = 1'b0;
    core_addr = '0;
    core_din  = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h5000_0000 + 32'(i);
      ref_mem[i] = 32'h5000_0000 + 32'(i);
    end
    mem[32]     = 32'h55;
    ref_mem[32] = 32'h55;
    #1;
    chk("reset_empty", {31'd0, sb_empty}, 32'd1);
    chk("reset_mem_wr", {31'd0, Mem_wr}, 32'd0);
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;

    // Store then forward-hit, then drain.
    cyc(0, 1, 32'h10, 32'hDEAD_BEEF);
    chk("st_no_stall", {31'd0, core_stall}, 32'd0);
    cyc(1, 0, 32'h10, 32'd0);
    chk("hit_dout", core_dout, 32'hDEAD_BEEF);
    chk("hit_mem_rd", {31'd0, Mem_rd}, 32'd0);
    idle();
    chk("hit_mem4", mem[4], 32'hDEAD_BEEF);
    chk("hit_empty", {31'd0, sb_empty}, 32'd1);

    // Youngest of duplicate addresses wins.
    cyc(0, 1, 32'h20, 32'd1);
    cyc(0, 1, 32'h20, 32'd2);
    cyc(0, 1, 32'h24, 32'd3);
    cyc(1, 0, 32'h20, 32'd0);
    chk("young_dout", core_dout, 32'd2);
    wait_empty("young_empty");
    chk("young_mem8", mem[8], 32'd2);
    chk("young_mem9", mem[9], 32'd3);

    // Fifth store into a full buffer stalls exactly once.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'(i * 4), 32'hA0 + 32'(i));
      if (i < 4) chk("full_nostall", {31'd0, core_stall}, 32'd0);
    end
    chk("full_stall", {31'd0, core_stall}, 32'd1);
    chk("full_mem_wr", {31'd0, Mem_wr}, 32'd1);
    chk("full_mem_addr", Mem_Addr, 32'h0);
    cyc(0, 1, 32'h10, 32'hA4);
    chk("full_accept", {31'd0, core_stall}, 32'd0);
    wait_empty("full_empty");
    for (int i = 0; i < 5; i++)
      chk("full_mem", mem[i], 32'hA0 + 32'(i));

    // A load miss holds off the drain for one cycle.
    cyc(0, 1, 32'h40, 32'd7);
    cyc(1, 0, 32'h80, 32'd0);
    chk("miss_dout", core_dout, 32'h55);
    chk("miss_mem_rd", {31'd0, Mem_rd}, 32'd1);
    chk("miss_mem_wr", {31'd0, Mem_wr}, 32'd0);
    idle();
    chk("miss_drain_wr", {31'd0, Mem_wr}, 32'd1);
    chk("miss_drain_addr", Mem_Addr, 32'h40);
    idle();
    chk("miss_mem16", mem[16], 32'd7);

    // Pointer wrap with alternating store/idle.
    for (int i = 0; i < 10; i++) begin
      wv[i] = $urandom;
      cyc(0, 1, 32'h200 + 32'(i * 4), wv[i]);
      chk("wrap_nostall", {31'd0, core_stall}, 32'd0);
      idle();
    end
    wait_empty("wrap_empty");
    for (int i = 0; i < 10; i++)
      chk("wrap_mem", mem[128 + i], wv[i]);

    // Reset between edges discards pending stores.
    cyc(0, 1, 32'h60, 32'h111);
    cyc(0, 1, 32'h64, 32'h222);
    cyc(0, 1, 32'h68, 32'h333);
    @(posedge CLK);
    #1;
    core_wr = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("rstmid_empty", {31'd0, sb_empty}, 32'd1);
    chk("rstmid_mem_wr", {31'd0, Mem_wr}, 32'd0);
    @(posedge CLK);
    #2 Reset = 1'b0;
    repeat (4) idle();
    chk("rstmid_mem24", mem[24], 32'h5000_0018);
    chk("rstmid_mem25", mem[25], 32'h5000_0019);
    chk("rstmid_mem26", mem[26], 32'h5000_001A);

    // Random traffic; a stalled store is held until accepted.
    rd_r = 0;
    wr_r = 0;
    a_r  = '0;
    d_r  = '0;
    for (int n = 0; n < 500; n++) begin
      if (!(core_stall && core_wr && !core_rd)) begin
        int r;
        r    = int'($urandom_range(0, 9));
        rd_r = (r < 3) || (r == 7);
        wr_r = (r >= 3 && r <= 7);
        a_r  = 32'h300 + 32'($urandom_range(0, 7) * 4)
             + 32'($urandom_range(0, 3));
        d_r  = $urandom;
      end
      cyc(rd_r, wr_r, a_r, d_r);
    end
    wait_empty("rand_empty");
    idle();
    bad = 0;
    for (int w = 0; w < 256; w++)
      if (mem[w] !== ref_mem[w]) bad++;
    chk("rand_mem_words_bad", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
